// File: rtl/mvb_crc_sequencer_if.sv
// ----------------------------------------------------------------------------
// mvb_crc_sequencer_if
//
// Groups the signals around the MVB CRC frame sequencer:
//   frame_start, frame_len   frame delimiter -> sequencer (frame announcement)
//   bit_valid, bit_in        Manchester decoder -> sequencer (decoded bits)
//   crc_error                CRC checker -> sequencer (per-group error flag)
//   crc_ready, crc_read,
//   crc_data                 sequencer -> CRC checker (serial strobes)
//   busy, frame_done,
//   frame_error,
//   group_err_cnt, timeout   sequencer -> frame buffer (per-frame result)
//
// Modports:
//   master  the surrounding receive chain (decoder, delimiter, checker, buffer)
//   slave   the sequencer itself
// ----------------------------------------------------------------------------
interface mvb_crc_sequencer_if;
    logic       frame_start;
    logic [2:0] frame_len;
    logic       bit_valid;
    logic       bit_in;
    logic       crc_error;
    logic       crc_ready;
    logic       crc_read;
    logic       crc_data;
    logic       busy;
    logic       frame_done;
    logic       frame_error;
    logic [2:0] group_err_cnt;
    logic       timeout;

    modport master (
        output frame_start, frame_len, bit_valid, bit_in, crc_error,
        input  crc_ready, crc_read, crc_data, busy, frame_done, frame_error,
               group_err_cnt, timeout
    );

    modport slave (
        input  frame_start, frame_len, bit_valid, bit_in, crc_error,
        output crc_ready, crc_read, crc_data, busy, frame_done, frame_error,
               group_err_cnt, timeout
    );
endinterface

// File: rtl/mvb_crc_sequencer.sv
// ----------------------------------------------------------------------------
// mvb_crc_sequencer
//
// Frame-level controller for the serial MVB CRC checker. Counts the decoded
// bits of a received frame, splits it into data groups (at most GROUP_BITS
// bits) each followed by an 8-bit check sequence, strobes every bit into the
// checker exactly once, inserts one flush strobe after each check sequence,
// samples the checker's error flag and reports one result per frame.
//
// Ports:
//   clk_3M  3 MHz bit clock, rising edge
//   rst     asynchronous, active-high reset
//   bus     mvb_crc_sequencer_if.slave
//     frame_start/frame_len  frame announcement (len code 0..4 = 16..256 bits)
//     bit_valid/bit_in       decoded bit strobe, MSB first
//     crc_error              checker error flag, sampled once per group
//     crc_ready/crc_read/crc_data  checker strobes, 1 cycle after bit_valid
//     busy                   accepted frame_start .. frame_done
//     frame_done             1-cycle result pulse
//     frame_error/group_err_cnt/timeout  result, held until next frame_start
// ----------------------------------------------------------------------------
module mvb_crc_sequencer #(
    parameter int TIMEOUT_CYC = 48,
    parameter int GROUP_BITS  = 64
) (
    input  logic               clk_3M,
    input  logic               rst,
    mvb_crc_sequencer_if.slave bus
);

    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

    // gap_cnt reads 0 in the cycle after an accepted bit. Leaving DATA/CHECK,
    // the DONE cycle and the registered frame_done add three more cycles, so
    // the abort decision is taken three counts early: frame_done then lands
    // exactly TIMEOUT_CYC cycles after the last accepted bit_valid.
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYC - 3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CHECK,
        S_FLUSH,
        S_EVAL,
        S_DONE
    } state_t;

    // Data bits covered by one check sequence for a legal length code.
    function automatic logic [6:0] group_bits(input logic [2:0] code);
        int len;
        len = 16 << code;
        if (len > GROUP_BITS) len = GROUP_BITS;
        return 7'(len);
    endfunction

    // Number of groups minus one; the group counter counts down to zero.
    function automatic logic [1:0] last_group(input logic [2:0] code);
        int n;
        n = (16 << code) / GROUP_BITS;
        if (n < 1) n = 1;
        return 2'(n - 1);
    endfunction

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    state_t           state_q,  state_nxt;
    logic [6:0]       bit_cnt_q, bit_cnt_nxt;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_nxt;
    logic [1:0]       grp_cnt_q, grp_cnt_nxt;
    logic [6:0]       gbits_q,  gbits_nxt;
    logic [2:0]       err_cnt_q, err_cnt_nxt;
    logic             tmo_q,    tmo_nxt;

    logic             crc_ready_q,     crc_ready_nxt;
    logic             crc_read_q,      crc_read_nxt;
    logic             crc_data_q,      crc_data_nxt;
    logic             busy_q,          busy_nxt;
    logic             frame_done_q,    frame_done_nxt;
    logic             frame_error_q,   frame_error_nxt;
    logic [2:0]       group_err_cnt_q, group_err_cnt_nxt;
    logic             timeout_q,       timeout_nxt;

    always_comb begin
        state_nxt         = state_q;
        bit_cnt_nxt       = bit_cnt_q;
        gap_cnt_nxt       = gap_cnt_q;
        grp_cnt_nxt       = grp_cnt_q;
        gbits_nxt         = gbits_q;
        err_cnt_nxt       = err_cnt_q;
        tmo_nxt           = tmo_q;
        crc_ready_nxt     = 1'b0;
        crc_read_nxt      = 1'b0;
        crc_data_nxt      = 1'b0;
        frame_done_nxt    = 1'b0;
        frame_error_nxt   = frame_error_q;
        group_err_cnt_nxt = group_err_cnt_q;
        timeout_nxt       = timeout_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.frame_start) begin
                    frame_error_nxt   = 1'b0;
                    group_err_cnt_nxt = 3'd0;
                    timeout_nxt       = 1'b0;
                    err_cnt_nxt       = 3'd0;
                    bit_cnt_nxt       = 7'd0;
                    gap_cnt_nxt       = '0;
                    if (bus.frame_len <= 3'd4) begin
                        state_nxt   = S_DATA;
                        gbits_nxt   = group_bits(bus.frame_len);
                        grp_cnt_nxt = last_group(bus.frame_len);
                        tmo_nxt     = 1'b0;
                    end else begin
                        // Illegal length: report as an aborted frame.
                        state_nxt = S_DONE;
                        tmo_nxt   = 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (bus.bit_valid) begin
                    crc_ready_nxt = 1'b1;
                    crc_data_nxt  = bus.bit_in;
                    gap_cnt_nxt   = '0;
                    if (bit_cnt_q + 7'd1 == gbits_q) begin
                        bit_cnt_nxt = 7'd0;
                        state_nxt   = S_CHECK;
                    end else begin
                        bit_cnt_nxt = bit_cnt_q + 7'd1;
                    end
                end else if (gap_cnt_q == GAP_LIMIT) begin
                    state_nxt = S_DONE;
                    tmo_nxt   = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt_q + 1'b1;
                end
            end

            S_CHECK: begin
                if (bus.bit_valid) begin
                    crc_ready_nxt = 1'b1;
                    crc_read_nxt  = 1'b1;
                    crc_data_nxt  = bus.bit_in;
                    gap_cnt_nxt   = '0;
                    if (bit_cnt_q == 7'd7) begin
                        bit_cnt_nxt = 7'd0;
                        state_nxt   = S_FLUSH;
                    end else begin
                        bit_cnt_nxt = bit_cnt_q + 7'd1;
                    end
                end else if (gap_cnt_q == GAP_LIMIT) begin
                    state_nxt = S_DONE;
                    tmo_nxt   = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt_q + 1'b1;
                end
            end

            S_FLUSH: begin
                // One extra read strobe with a zero bit lets the checker
                // settle its error flag; any bit_valid here is dropped.
                crc_ready_nxt = 1'b1;
                crc_read_nxt  = 1'b1;
                state_nxt     = S_EVAL;
            end

            S_EVAL: begin
                if (bus.crc_error) err_cnt_nxt = sat_inc3(err_cnt_q);
                if (grp_cnt_q != 2'd0) begin
                    grp_cnt_nxt = grp_cnt_q - 2'd1;
                    state_nxt   = S_DATA;
                end else begin
                    state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                frame_done_nxt    = 1'b1;
                frame_error_nxt   = (err_cnt_q != 3'd0) || tmo_q;
                group_err_cnt_nxt = err_cnt_q;
                timeout_nxt       = tmo_q;
                state_nxt         = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // ---- register stage: state, counters and all outputs ----
    always_ff @(posedge clk_3M or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            bit_cnt_q       <= 7'd0;
            gap_cnt_q       <= '0;
            grp_cnt_q       <= 2'd0;
            gbits_q         <= 7'd0;
            err_cnt_q       <= 3'd0;
            tmo_q           <= 1'b0;
            crc_ready_q     <= 1'b0;
            crc_read_q      <= 1'b0;
            crc_data_q      <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_error_q   <= 1'b0;
            group_err_cnt_q <= 3'd0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            bit_cnt_q       <= bit_cnt_nxt;
            gap_cnt_q       <= gap_cnt_nxt;
            grp_cnt_q       <= grp_cnt_nxt;
            gbits_q         <= gbits_nxt;
            err_cnt_q       <= err_cnt_nxt;
            tmo_q           <= tmo_nxt;
            crc_ready_q     <= crc_ready_nxt;
            crc_read_q      <= crc_read_nxt;
            crc_data_q      <= crc_data_nxt;
            busy_q          <= busy_nxt;
            frame_done_q    <= frame_done_nxt;
            frame_error_q   <= frame_error_nxt;
            group_err_cnt_q <= group_err_cnt_nxt;
            timeout_q       <= timeout_nxt;
        end
    end

    assign bus.crc_ready     = crc_ready_q;
    assign bus.crc_read      = crc_read_q;
    assign bus.crc_data      = crc_data_q;
    assign bus.busy          = busy_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.frame_error   = frame_error_q;
    assign bus.group_err_cnt = group_err_cnt_q;
    assign bus.timeout       = timeout_q;

endmodule

// File: doc/mvb_crc_sequencer.md
Name: mvb_crc_sequencer

Overview:
Frame-level controller for the serial MVB CRC checker. It counts the decoded bits of a received frame and splits the frame into data groups and 8-bit check sequences. It drives the checker's crc_ready, crc_read and data strobes, samples the checker's error flag after each check sequence and reports a single pass/fail result per frame. It sits between the Manchester decoder/frame delimiter and the frame buffer, on the 3 MHz bit clock.

Parameters:
TIMEOUT_CYC, 48, max clk_3M cycles between bit_valid strobes inside a frame before the frame is aborted
GROUP_BITS, 64, max data bits covered by one check sequence (MVB fixed value)

Ports:
clk_3M  input  1  3 MHz bit clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
frame_start  input  1  1-cycle pulse: first bit of a new frame follows; sampled only in IDLE
frame_len  input  3  length code latched with frame_start: 0=16, 1=32, 2=64, 3=128, 4=256 data bits; 5-7 illegal
bit_valid  input  1  1-cycle strobe: bit_in is a new decoded bit
bit_in  input  1  decoded serial bit, MSB first
crc_error  input  1  error flag from the CRC checker
crc_ready  output  1  to checker: process crc_data this cycle
crc_read  output  1  to checker: 1 = check-sequence or flush bit, 0 = data bit
crc_data  output  1  to checker: serial bit
busy  output  1  high from an accepted frame_start until frame_done
frame_done  output  1  1-cycle pulse: frame result valid
frame_error  output  1  valid with frame_done; held until the next frame_start
group_err_cnt  output  3  number of failed check groups in the last frame; held like frame_error
timeout  output  1  valid with frame_done; 1 = frame aborted on gap or illegal length

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-frame abandons the frame with no frame_done.
- All outputs are registered. crc_ready, crc_read and crc_data are valid 1 cycle after the bit_valid that produced them.
- States:
  - IDLE -> DATA on frame_start with a legal frame_len. Latch groups = max(1, len/64) and gbits = min(len, 64). Clear err_cnt, bit_cnt, gap_cnt.
  - IDLE -> DONE on frame_start with an illegal frame_len, setting timeout=1 and frame_error=1.
  - DATA: each bit_valid gives 1 cycle of crc_ready=1, crc_read=0, crc_data=bit_in, and bit_cnt+1. When bit_cnt reaches gbits, go to CHECK and clear bit_cnt.
  - CHECK: each bit_valid gives 1 cycle of crc_ready=1, crc_read=1, crc_data=bit_in. After the 8th check bit, go to FLUSH.
  - FLUSH: exactly 1 cycle with crc_ready=1, crc_read=1, crc_data=0. Ignores bit_valid. Go to EVAL.
  - EVAL: 1 cycle; sample crc_error and increment err_cnt (saturating at 7) if it is 1.
    - If the group counter is not exhausted, decrement it and go to DATA.
    - Otherwise go to DONE.
  - DONE: frame_done=1 for 1 cycle; frame_error = (err_cnt != 0) or timeout; group_err_cnt = err_cnt. Go to IDLE.
- crc_ready is 0 in every cycle not listed above. The checker never sees a held or duplicated bit.
- gap_cnt counts up in DATA and CHECK in cycles without bit_valid and clears on bit_valid.
  - When gap_cnt reaches TIMEOUT_CYC, go to DONE with timeout=1 and frame_error=1.
  - group_err_cnt reports the groups evaluated so far.
- bit_valid in FLUSH, EVAL, DONE or IDLE is dropped. The upstream guarantees a gap of at least 3 cycles after each 8th check bit.
- frame_start while busy is ignored; the current frame continues.
- Simultaneous bit_valid and gap_cnt==TIMEOUT_CYC: the bit is accepted and the timeout does not fire.
- Bit counter is 7 bits wide; the group counter is 2 bits wide, so 256 bits = 4 groups.

Test Plan:
- frame_len=0 with 16 data bits and 8 correct CRC bits, bits every 2 cycles -> 16 data strobes, then 8 read strobes, then 1 flush. frame_done follows 2 cycles after the flush; frame_error=0, group_err_cnt=0.
- frame_len=4 with 4 groups, group 3 CRC corrupted -> 4 flush cycles; frame_done with frame_error=1, group_err_cnt=1, timeout=0.
- frame_len=1 with the stream stopping after 20 bits -> frame_done exactly TIMEOUT_CYC cycles after the last bit_valid; timeout=1, frame_error=1, group_err_cnt=0.
- frame_len=6 -> frame_done 2 cycles after frame_start; timeout=1; crc_ready never asserted.
- Second frame_start issued mid-frame, plus bit_valid during FLUSH -> both ignored; crc_ready count = 16+8+1 per 16-bit frame.
- rst pulsed during CHECK -> all outputs 0 immediately; next frame_start runs a clean frame with frame_error=0.
